// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the fifo_rd_stream read-side adapter.
//   state_e         : control FSM states (idle / active reading / draining)
//   SkidDepth       : number of entries in the output skid buffer
//   burst_cnt_width : bit width of a 0..burst_len-1 counter (never below 1)
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain
    } state_e;

    localparam int unsigned SkidDepth = 2;

    function automatic int unsigned burst_cnt_width(input int unsigned burst_len);
        return (burst_len <= 2) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order skid buffer carrying a data word plus a last flag.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i            : write {last_i, data_i} at the tail this cycle
//   data_i, last_i    : payload to push
//   pop_i             : drop the head entry this cycle (only while valid_o)
//   valid_o           : buffer not empty
//   data_o, last_o    : head entry payload (zero while empty)
//   count_o           : number of occupied entries, 0..2
// Push and pop may coincide; the caller guarantees no push while full without pop.
module stream_skid2
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             last_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    // Each entry is {last, data}; entry 0 is always the head.
    logic [SkidDepth-1:0][Width:0] ent_q, ent_d;
    logic [1:0]                    count_q, count_d;
    logic                          wr_sel;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        // Tail slot after any pop this cycle: slot 1 only if one word remains ahead.
        wr_sel  = pop_i ? (count_q == 2'd2) : (count_q == 2'd1);
        if (pop_i) begin
            ent_d[0] = ent_q[1];
        end
        if (push_i) begin
            ent_d[wr_sel] = {last_i, data_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_q   <= '0;
            count_q <= 2'd0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = valid_o ? ent_q[0][Width-1:0] : '0;
    assign last_o  = valid_o & ent_q[0][Width];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for asynfifo (rclk domain): turns the one-cycle-latency
// ren/rdata/empty pull interface into a valid/ready stream grouped into bursts.
// Ports:
//   rclk, rst   : read clock, asynchronous active-high reset
//   en          : permits new FIFO reads
//   ren         : FIFO read enable (never asserted while empty)
//   rdata       : FIFO data, valid the cycle after ren
//   empty       : FIFO empty flag
//   out_valid/out_ready/out_data/out_last : output stream, out_last ends a burst
//   busy        : FSM not idle
// Optional feature macro FIFO_RD_STREAM_PAD_EN: when defined, a partial burst
// left at the end of a drain is completed with zero-data pad words.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              en,
    output logic              ren,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned     CntW    = burst_cnt_width(BURST_LEN);
    localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LEN - 1);
    localparam logic [CntW+1:0] BurstW  = (CntW + 2)'(BURST_LEN);

    state_e            state_q, state_d;
    logic              inflight_q;
    logic [CntW-1:0]   bcnt_q, bcnt_d;

    logic              sk_valid, sk_last, sk_pop, push_last;
    logic [DWIDTH-1:0] sk_data;
    logic [1:0]        sk_count;
    logic              pad_active, drain_done, pop;
    logic [CntW+1:0]   pos_sum;

    stream_skid2 #(
        .Width (DWIDTH)
    ) u_skid (
        .clk_i   (rclk),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .data_i  (rdata),
        .last_i  (push_last),
        .pop_i   (sk_pop),
        .valid_o (sk_valid),
        .data_o  (sk_data),
        .last_o  (sk_last),
        .count_o (sk_count)
    );

`ifdef FIFO_RD_STREAM_PAD_EN
    always_comb begin
        pad_active = (state_q == StDrain) && (sk_count == 2'd0) && !inflight_q &&
                     (bcnt_q != '0);
        drain_done = (bcnt_q == '0);
    end
`else
    always_comb begin
        pad_active = 1'b0;
        drain_done = 1'b1;
    end
`endif

    // Burst position of a word entering the buffer: it sits behind every word
    // already buffered, and the head always has position bcnt_q.
    always_comb begin
        pos_sum = {2'b00, bcnt_q} + {{CntW{1'b0}}, sk_count};
        if (pos_sum >= BurstW) begin
            pos_sum = pos_sum - BurstW;
        end
        if (pos_sum >= BurstW) begin
            pos_sum = pos_sum - BurstW;
        end
        push_last = (pos_sum == {2'b00, LastIdx});
    end

    always_comb begin
        out_valid = sk_valid | pad_active;
        out_data  = sk_data;
        out_last  = sk_valid ? sk_last : (pad_active && (bcnt_q == LastIdx));
        pop       = out_valid & out_ready;
        sk_pop    = sk_valid & out_ready;
        busy      = (state_q != StIdle);
        // Words owed to the buffer after this cycle must stay within its 2 entries.
        ren       = (state_q == StActive) && !empty &&
                    (({1'b0, sk_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (pop) begin
            bcnt_d = (bcnt_q == LastIdx) ? '0 : bcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) state_d = StActive;
            end
            StActive: begin
                if (!en) state_d = StDrain;
            end
            StDrain: begin
                if (en) begin
                    state_d = StActive;
                end else if ((sk_count == 2'd0) && !inflight_q && drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= ren;
            bcnt_q     <= bcnt_d;
        end
    end

endmodule
